// File: rtl/button_debouncer_if.sv
// Button bundle between raw PMOD pins and the debounced event outputs.
// The debouncer sits on the slave side; whoever drives the pins uses master.
interface button_debouncer_if #(
    parameter int NUM_BTN = 2
);
    logic [NUM_BTN-1:0] pmod;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [NUM_BTN-1:0] btn_long;

    modport master (
        output pmod,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  pmod,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/button_debouncer.sv
// Per-button synchroniser and debounce FSM producing a clean level plus
// single-cycle press, release and long-press pulses.
module button_debouncer #(
    parameter int NUM_BTN           = 2,
    parameter int ACTIVE_LOW        = 1,
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int LONG_PRESS_CYCLES = 12000000
) (
    input  logic                clk_12M,
    input  logic                rst,
    button_debouncer_if.slave   bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic RELEASED_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 1) begin : g_param_check
        $fatal(1, "button_debouncer: DEBOUNCE_CYCLES must be >= 2 and LONG_PRESS_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    logic [NUM_BTN-1:0] level_vec;
    logic [NUM_BTN-1:0] press_vec;
    logic [NUM_BTN-1:0] release_vec;
    logic [NUM_BTN-1:0] long_vec;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
        state_e          state_q, state_d;
        logic [DW-1:0]   dcnt_q, dcnt_d;
        logic [HW-1:0]   hcnt_q, hcnt_d;
        logic            long_done_q, long_done_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            long_q, long_d;
        logic            sync1_q, sync2_q;
        logic            s;
        logic            hold_tick;

        assign s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

        always_ff @(posedge clk_12M) begin
            if (rst) begin
                sync1_q     <= RELEASED_RAW;
                sync2_q     <= RELEASED_RAW;
                state_q     <= IDLE;
                dcnt_q      <= '0;
                hcnt_q      <= '0;
                long_done_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                long_q      <= 1'b0;
            end else begin
                sync1_q     <= bus.pmod[gi];
                sync2_q     <= sync1_q;
                state_q     <= state_d;
                dcnt_q      <= dcnt_d;
                hcnt_q      <= hcnt_d;
                long_done_q <= long_done_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                long_q      <= long_d;
            end
        end

        always_comb begin
            state_d     = state_q;
            dcnt_d      = dcnt_q;
            hcnt_d      = hcnt_q;
            long_done_d = long_done_q;
            level_d     = level_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            long_d      = 1'b0;
            hold_tick   = 1'b0;

            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_WAIT;
                        dcnt_d  = DW'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (dcnt_q == D_LAST) begin
                        state_d = PRESSED;
                        press_d = 1'b1;
                        level_d = 1'b1;
                        hcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_d = RELEASE_WAIT;
                        dcnt_d  = DW'(1);
                    end else begin
                        hold_tick = 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    // Returning to pressed counts as a held cycle, so a bounce
                    // only pauses hcnt for the cycles the pin actually read released.
                    if (s) begin
                        state_d   = PRESSED;
                        hold_tick = 1'b1;
                    end else if (dcnt_q == D_LAST) begin
                        state_d     = IDLE;
                        release_d   = 1'b1;
                        level_d     = 1'b0;
                        long_done_d = 1'b0;
                        hcnt_d      = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (hold_tick && !long_done_q) begin
                if (hcnt_q == H_LAST) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
        end

        assign level_vec[gi]   = level_q;
        assign press_vec[gi]   = press_q;
        assign release_vec[gi] = release_q;
        assign long_vec[gi]    = long_q;
    end

    assign bus.btn_level   = level_vec;
    assign bus.btn_press   = press_vec;
    assign bus.btn_release = release_vec;
    assign bus.btn_long    = long_vec;
endmodule
